// File: rtl/io_arbiter_if.sv
// Bundle of the core-side request/response signals and the external IO bus.
// master: the arbiter; slave: the cores and the device together.
interface io_arbiter_if #(
    parameter int unsigned NUM_CORES        = 4,
    parameter int unsigned THREAD_IDX_WIDTH = 2
);
    localparam int unsigned CoreWidth = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0]                  ior_request_valid;
    logic [NUM_CORES-1:0]                  ior_store;
    logic [NUM_CORES*32-1:0]               ior_address;
    logic [NUM_CORES*32-1:0]               ior_value;
    logic [NUM_CORES*THREAD_IDX_WIDTH-1:0] ior_thread_idx;
    logic [NUM_CORES-1:0]                  ii_ready;
    logic                                  ii_response_valid;
    logic [CoreWidth-1:0]                  ii_response_core;
    logic [THREAD_IDX_WIDTH-1:0]           ii_response_thread_idx;
    logic [31:0]                           ii_response_read_value;
    logic                                  io_read_en;
    logic                                  io_write_en;
    logic [31:0]                           io_address;
    logic [31:0]                           io_write_data;
    logic                                  io_ack;
    logic [31:0]                           io_read_data;
    logic                                  io_timeout;

    modport master (
        input  ior_request_valid, ior_store, ior_address, ior_value, ior_thread_idx,
        input  io_ack, io_read_data,
        output ii_ready, ii_response_valid, ii_response_core, ii_response_thread_idx,
        output ii_response_read_value, io_read_en, io_write_en, io_address, io_write_data,
        output io_timeout
    );

    modport slave (
        output ior_request_valid, ior_store, ior_address, ior_value, ior_thread_idx,
        output io_ack, io_read_data,
        input  ii_ready, ii_response_valid, ii_response_core, ii_response_thread_idx,
        input  ii_response_read_value, io_read_en, io_write_en, io_address, io_write_data,
        input  io_timeout
    );
endinterface

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing one IO bus among NUM_CORES request queues.
// Define IO_TIMEOUT_EN to abort bus transactions after TIMEOUT_CYCLES without io_ack.
module io_arbiter #(
    parameter int unsigned NUM_CORES        = 4,
    parameter int unsigned THREAD_IDX_WIDTH = 2,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input logic         clk,
    input logic         reset,
    io_arbiter_if.master bus
);
    localparam int unsigned CoreW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StRespond} state_e;

    state_e                      state_q, state_d;
    logic [CoreW-1:0]            ptr_q, ptr_d;
    logic [CoreW-1:0]            core_q, core_d;
    logic                        store_q, store_d;
    logic [31:0]                 addr_q, addr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic [THREAD_IDX_WIDTH-1:0] thread_q, thread_d;
    logic [CoreW-1:0]            resp_core_q, resp_core_d;
    logic [THREAD_IDX_WIDTH-1:0] resp_thread_q, resp_thread_d;
    logic [31:0]                 resp_data_q, resp_data_d;
`ifdef IO_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        timeout_q, timeout_d;
`endif

    logic [31:0]                 addr_arr   [NUM_CORES];
    logic [31:0]                 value_arr  [NUM_CORES];
    logic [THREAD_IDX_WIDTH-1:0] thread_arr [NUM_CORES];
    logic [CoreW:0]              cand;
    logic                        grant_found;
    logic [CoreW-1:0]            grant_idx;

    always_comb begin
        for (int unsigned c = 0; c < NUM_CORES; c++) begin
            addr_arr[c]   = bus.ior_address[c*32 +: 32];
            value_arr[c]  = bus.ior_value[c*32 +: 32];
            thread_arr[c] = bus.ior_thread_idx[c*THREAD_IDX_WIDTH +: THREAD_IDX_WIDTH];
        end
    end

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            cand = {1'b0, ptr_q} + (CoreW+1)'(i);
            if (cand >= (CoreW+1)'(NUM_CORES)) cand = cand - (CoreW+1)'(NUM_CORES);
            if (!grant_found && bus.ior_request_valid[cand[CoreW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CoreW-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        core_d        = core_q;
        store_d       = store_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        thread_d      = thread_q;
        resp_core_d   = resp_core_q;
        resp_thread_d = resp_thread_q;
        resp_data_d   = resp_data_q;
`ifdef IO_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    core_d   = grant_idx;
                    store_d  = bus.ior_store[grant_idx];
                    addr_d   = addr_arr[grant_idx];
                    wdata_d  = value_arr[grant_idx];
                    thread_d = thread_arr[grant_idx];
                    ptr_d    = (grant_idx == CoreW'(NUM_CORES - 1)) ? '0 : grant_idx + CoreW'(1);
                    state_d  = StIssue;
`ifdef IO_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            StIssue: begin
                if (bus.io_ack) begin
                    resp_core_d   = core_q;
                    resp_thread_d = thread_q;
                    resp_data_d   = store_q ? 32'h0 : bus.io_read_data;
                    state_d       = StRespond;
                end
`ifdef IO_TIMEOUT_EN
                // An ack on the limit cycle takes the branch above and wins.
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    resp_core_d   = core_q;
                    resp_thread_d = thread_q;
                    resp_data_d   = 32'hFFFF_FFFF;
                    timeout_d     = 1'b1;
                    state_d       = StRespond;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            core_q        <= '0;
            store_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            thread_q      <= '0;
            resp_core_q   <= '0;
            resp_thread_q <= '0;
            resp_data_q   <= '0;
`ifdef IO_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            core_q        <= core_d;
            store_q       <= store_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            thread_q      <= thread_d;
            resp_core_q   <= resp_core_d;
            resp_thread_q <= resp_thread_d;
            resp_data_q   <= resp_data_d;
`ifdef IO_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign bus.ii_ready = (state_q == StIdle && !reset && grant_found) ?
                          (NUM_CORES'(1) << grant_idx) : '0;
    assign bus.ii_response_valid      = (state_q == StRespond);
    assign bus.ii_response_core       = resp_core_q;
    assign bus.ii_response_thread_idx = resp_thread_q;
    assign bus.ii_response_read_value = resp_data_q;
    assign bus.io_read_en             = (state_q == StIssue) && !store_q;
    assign bus.io_write_en            = (state_q == StIssue) && store_q;
    assign bus.io_address             = addr_q;
    assign bus.io_write_data          = wdata_q;
`ifdef IO_TIMEOUT_EN
    assign bus.io_timeout             = timeout_q;
`else
    assign bus.io_timeout             = 1'b0;
`endif
endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: reads, writes, round-robin order, reset mid-transaction
// and (with IO_TIMEOUT_EN) the bus timeout.
module tb_io_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    io_arbiter_if #(.NUM_CORES(4), .THREAD_IDX_WIDTH(2)) bus ();

    io_arbiter #(.NUM_CORES(4), .THREAD_IDX_WIDTH(2), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ior_request_valid = '0;
        bus.ior_store         = '0;
        bus.ior_address       = '0;
        bus.ior_value         = '0;
        bus.ior_thread_idx    = '0;
        bus.io_ack            = 1'b0;
        bus.io_read_data      = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int core, input bit store, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] thread);
        bus.ior_store[core]             = store;
        bus.ior_address[core*32 +: 32]  = addr;
        bus.ior_value[core*32 +: 32]    = wdata;
        bus.ior_thread_idx[core*2 +: 2] = thread;
        bus.ior_request_valid[core]     = 1'b1;
    endtask

    // Expects a grant of 'core' now, acks on the ack_delay-th strobe cycle.
    task automatic run_txn(input int core, input int ack_delay, input logic [31:0] rdata,
                           input bit store, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] thread, input bit drop);
        logic [3:0]  onehot;
        logic [31:0] exp_val;
        onehot  = 4'b0001 << core;
        exp_val = store ? 32'h0 : rdata;
        #1;
        check("grant", bus.ii_ready, onehot);
        tick();
        if (drop) bus.ior_request_valid[core] = 1'b0;
        for (int k = 1; k <= ack_delay; k++) begin
            #1;
            check("read_en", bus.io_read_en, !store);
            check("write_en", bus.io_write_en, store);
            check("address", bus.io_address, addr);
            if (store) check("wdata", bus.io_write_data, wdata);
            check("ready_issue", bus.ii_ready, 4'b0);
            check("no_resp_issue", bus.ii_response_valid, 1'b0);
            if (k == ack_delay) begin
                bus.io_ack       = 1'b1;
                bus.io_read_data = rdata;
            end
            tick();
        end
        bus.io_ack       = 1'b0;
        bus.io_read_data = 32'h0BAD_0BAD;
        #1;
        check("resp_valid", bus.ii_response_valid, 1'b1);
        check("resp_core", bus.ii_response_core, core[1:0]);
        check("resp_thread", bus.ii_response_thread_idx, thread);
        check("resp_value", bus.ii_response_read_value, exp_val);
        check("strobe_off", {bus.io_read_en, bus.io_write_en}, 2'b00);
        check("timeout_idle", bus.io_timeout, 1'b0);
        check("ready_resp", bus.ii_ready, 4'b0);
        tick();
        check("resp_pulse", bus.ii_response_valid, 1'b0);
        check("resp_hold", bus.ii_response_read_value, exp_val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got stuck expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        do_reset();
        #1;
        check("rst_ready", bus.ii_ready, 4'b0);
        check("rst_resp", bus.ii_response_valid, 1'b0);
        check("rst_strobes", {bus.io_read_en, bus.io_write_en}, 2'b00);
        check("rst_addr", bus.io_address, 32'h0);
        check("rst_value", bus.ii_response_read_value, 32'h0);
        check("rst_timeout", bus.io_timeout, 1'b0);

        // Single read, then single write.
        set_req(2, 1'b0, 32'h0000_0100, 32'h0, 2'd3);
        run_txn(2, 5, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 32'h0, 2'd3, 1'b1);
        set_req(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 2'd1);
        run_txn(0, 3, 32'hCAFE_F00D, 1'b1, 32'h0000_0010, 32'h1234_5678, 2'd1, 1'b1);

        // io_ack outside ISSUE is ignored.
        bus.io_ack = 1'b1;
        tick();
        check("stray_ack_resp", bus.ii_response_valid, 1'b0);
        check("stray_ack_strobe", {bus.io_read_en, bus.io_write_en}, 2'b00);
        bus.io_ack = 1'b0;
        tick();
        check("stray_ack_resp2", bus.ii_response_valid, 1'b0);

        // Contention: all cores request continuously from reset.
        do_reset();
        for (int c = 0; c < 4; c++) set_req(c, 1'b0, 32'h1000 + 32'(16 * c), 32'h0, 2'(c));
        for (int n = 0; n < 5; n++) begin
            int c;
            c = n % 4;
            run_txn(c, 1, 32'hA000_0000 + 32'(c), 1'b0, 32'h1000 + 32'(16 * c), 32'h0,
                    2'(c), 1'b0);
        end
        clear_inputs();

        // Fairness: pointer moved to 2 by a core 1 grant, then cores 0 and 3 compete.
        do_reset();
        set_req(1, 1'b0, 32'h20, 32'h0, 2'd0);
        run_txn(1, 2, 32'h1111_1111, 1'b0, 32'h20, 32'h0, 2'd0, 1'b1);
        set_req(0, 1'b0, 32'h40, 32'h0, 2'd2);
        set_req(3, 1'b1, 32'h80, 32'h7777_0000, 2'd1);
        run_txn(3, 2, 32'h0, 1'b1, 32'h80, 32'h7777_0000, 2'd1, 1'b1);
        run_txn(0, 1, 32'h0000_0040, 1'b0, 32'h40, 32'h0, 2'd2, 1'b1);

        // Reset in the second ISSUE cycle (cycle 3 counting the grant as cycle 1).
        do_reset();
        set_req(2, 1'b0, 32'h200, 32'h0, 2'd1);
        #1;
        check("mid_grant", bus.ii_ready, 4'b0100);
        tick();
        bus.ior_request_valid = '0;
        #1;
        check("mid_strobe_on", bus.io_read_en, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        check("mid_strobe_off", {bus.io_read_en, bus.io_write_en}, 2'b00);
        check("mid_no_resp", bus.ii_response_valid, 1'b0);
        reset = 1'b0;
        tick();
        check("mid_no_resp2", bus.ii_response_valid, 1'b0);
        check("mid_idle_ready", bus.ii_ready, 4'b0);
        set_req(0, 1'b0, 32'h300, 32'h0, 2'd0);
        set_req(3, 1'b0, 32'h310, 32'h0, 2'd3);
        run_txn(0, 1, 32'h0000_0300, 1'b0, 32'h300, 32'h0, 2'd0, 1'b1);
        clear_inputs();

`ifdef IO_TIMEOUT_EN
        // No ack: forced completion after 8 ISSUE cycles.
        do_reset();
        set_req(1, 1'b0, 32'h500, 32'h0, 2'd2);
        #1;
        check("to_grant", bus.ii_ready, 4'b0010);
        tick();
        bus.ior_request_valid = '0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            check("to_wait_strobe", bus.io_read_en, 1'b1);
            check("to_wait_flag", bus.io_timeout, 1'b0);
            tick();
        end
        #1;
        check("to_resp_valid", bus.ii_response_valid, 1'b1);
        check("to_resp_value", bus.ii_response_read_value, 32'hFFFF_FFFF);
        check("to_pulse", bus.io_timeout, 1'b1);
        check("to_strobe_off", bus.io_read_en, 1'b0);
        tick();
        check("to_pulse_end", bus.io_timeout, 1'b0);
        // Ack on the 8th cycle wins over the timeout.
        set_req(1, 1'b0, 32'h504, 32'h0, 2'd2);
        run_txn(1, 8, 32'h55AA_33CC, 1'b0, 32'h504, 32'h0, 2'd2, 1'b1);
`else
        // Without the timeout the bus waits as long as the device takes.
        do_reset();
        set_req(1, 1'b0, 32'h500, 32'h0, 2'd2);
        run_txn(1, 12, 32'h55AA_33CC, 1'b0, 32'h500, 32'h0, 2'd2, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
